// File: rtl/conv_encoder_framer.sv
// Rate-1/2, K=3 convolutional encoder with frame handshaking.
// Each accepted word is sent LSB first, optionally followed by two zero tail bits.
module conv_encoder_framer #(
  parameter int         DATA_W  = 8,
  parameter logic [2:0] G0      = 3'b111,
  parameter logic [2:0] G1      = 3'b101,
  parameter bit         TAIL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [1:0]        o_sym,
  output logic              o_sym_valid,
  input  logic              i_sym_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam int IDX_W = $clog2(DATA_W) + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ENCODE = 2'd1;
  localparam logic [1:0] TAIL   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]        fsm;
  logic [DATA_W-1:0] word_q;
  logic [1:0]        enc_state;
  logic [IDX_W-1:0]  bit_idx;
  logic              tail_cnt;
  logic              ready_en;

  logic [DATA_W-1:0] word_shift;
  logic              cur_bit;
  logic [2:0]        taps;
  logic              sym_valid;
  logic              xfer;
  logic              last_bit;

  always_comb begin
    word_shift = word_q >> bit_idx;
    cur_bit    = (fsm == ENCODE) ? word_shift[0] : 1'b0;
    taps       = {cur_bit, enc_state};
    sym_valid  = (fsm == ENCODE) || (fsm == TAIL);
    xfer       = sym_valid && i_sym_ready;
    last_bit   = (bit_idx == IDX_W'(DATA_W - 1));
  end

  // ready_en keeps o_ready low until the first clock edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm       <= IDLE;
      word_q    <= '0;
      enc_state <= 2'b00;
      bit_idx   <= '0;
      tail_cnt  <= 1'b0;
      ready_en  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (fsm)
        IDLE: begin
          if (i_valid && o_ready) begin
            word_q    <= i_data;
            enc_state <= 2'b00;
            bit_idx   <= '0;
            tail_cnt  <= 1'b0;
            fsm       <= ENCODE;
          end
        end
        ENCODE: begin
          if (xfer) begin
            enc_state <= {cur_bit, enc_state[1]};
            if (last_bit) begin
              fsm <= TAIL_EN ? TAIL : DONE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        TAIL: begin
          if (xfer) begin
            enc_state <= {1'b0, enc_state[1]};
            tail_cnt  <= ~tail_cnt;
            if (tail_cnt) begin
              fsm <= DONE;
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_ready     = ready_en && (fsm == IDLE);
    o_busy      = (fsm != IDLE);
    o_done      = (fsm == DONE);
    o_sym_valid = sym_valid;
    o_sym       = sym_valid ? {^(G0 & taps), ^(G1 & taps)} : 2'b00;
  end

endmodule

// File: tb/tb_conv_encoder_framer.sv
// [TB] bench for conv_encoder_framer: one DUT with tail bits, one without,
// checked against a bit-serial convolutional code model.
module tb_conv_encoder_framer;

  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;
  localparam logic [1:0] E01 [10] = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00,
                                      2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [1:0] EFF [10] = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b10,
                                      2'b10, 2'b10, 2'b10, 2'b01, 2'b11};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_valid_a = 1'b0;
  logic       i_valid_b = 1'b0;
  logic       i_sym_ready = 1'b1;

  logic       o_ready_a, o_sym_valid_a, o_busy_a, o_done_a;
  logic [1:0] o_sym_a;
  logic       o_ready_b, o_sym_valid_b, o_busy_b, o_done_b;
  logic [1:0] o_sym_b;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] exp_syms [16];
  int         exp_len;
  logic [1:0] got_syms [32];
  int         got_len;
  int         done_cycles;
  bit         sel_b = 1'b0;

  conv_encoder_framer #(.DATA_W(8), .G0(G0), .G1(G1), .TAIL_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid_a),
    .o_ready(o_ready_a), .o_sym(o_sym_a), .o_sym_valid(o_sym_valid_a),
    .i_sym_ready(i_sym_ready), .o_busy(o_busy_a), .o_done(o_done_a)
  );

  conv_encoder_framer #(.DATA_W(8), .G0(G0), .G1(G1), .TAIL_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid_b),
    .o_ready(o_ready_b), .o_sym(o_sym_b), .o_sym_valid(o_sym_valid_b),
    .i_sym_ready(i_sym_ready), .o_busy(o_busy_b), .o_done(o_done_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic cur_ready();
    return sel_b ? o_ready_b : o_ready_a;
  endfunction
  function automatic logic cur_valid();
    return sel_b ? o_sym_valid_b : o_sym_valid_a;
  endfunction
  function automatic logic cur_done();
    return sel_b ? o_done_b : o_done_a;
  endfunction
  function automatic logic [1:0] cur_sym();
    return sel_b ? o_sym_b : o_sym_a;
  endfunction

  // Reference: data bits LSB first, then optional zero tail; each symbol is
  // the parity of the generator taps over {bit, previous bit, bit before}.
  task automatic model_frame(input logic [7:0] w, input bit tail);
    logic p1, p2, b;
    logic [2:0] v;
    logic [7:0] sh;
    p1 = 1'b0;
    p2 = 1'b0;
    exp_len = 8 + (tail ? 2 : 0);
    for (int i = 0; i < exp_len; i++) begin
      sh = w >> i;
      b  = (i < 8) ? sh[0] : 1'b0;
      v  = {b, p1, p2};
      exp_syms[i] = {^(G0 & v), ^(G1 & v)};
      p2 = p1;
      p1 = b;
    end
  endtask

  // Sends one word to the selected DUT and collects every transferred symbol.
  task automatic run_frame(input logic [7:0] w, input bit stalls, input bit use_b);
    int         budget;
    int         since;
    logic       prev_stall;
    logic [1:0] prev_sym;
    sel_b = use_b;
    got_len = 0;
    done_cycles = -1;
    for (int i = 0; i < 32; i++) got_syms[i] = 2'bxx;
    @(negedge clk);
    i_data = w;
    i_sym_ready = 1'b1;
    if (use_b) i_valid_b = 1'b1; else i_valid_a = 1'b1;
    budget = 0;
    while (!cur_ready() && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    vectors++;
    if (cur_ready() !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL accept_timeout o_ready=%b required 1", cur_ready());
    end
    @(negedge clk);
    i_valid_a = 1'b0;
    i_valid_b = 1'b0;
    i_data = 8'($urandom);
    vectors++;
    if (cur_valid() !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL first_sym_latency o_sym_valid=%b required 1", cur_valid());
    end
    since = 1;
    prev_stall = 1'b0;
    prev_sym = 2'b00;
    while (since < 200) begin
      if (prev_stall) begin
        vectors++;
        if (cur_valid() !== 1'b1 || cur_sym() !== prev_sym) begin
          miscompares++;
          $display("[TB] FAIL stall_hold valid=%b sym=%b required 1/%b",
                   cur_valid(), cur_sym(), prev_sym);
        end
      end
      if (cur_done() === 1'b1) break;
      i_sym_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cur_valid() && i_sym_ready && got_len < 32) begin
        got_syms[got_len] = cur_sym();
        got_len++;
      end
      prev_stall = cur_valid() && !i_sym_ready;
      prev_sym = cur_sym();
      @(negedge clk);
      since++;
    end
    done_cycles = since;
    vectors++;
    if (cur_done() !== 1'b1 || cur_valid() !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL done_seen o_done=%b o_sym_valid=%b required 1/0",
               cur_done(), cur_valid());
    end
    i_sym_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (cur_done() !== 1'b0 || cur_ready() !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL done_one_cycle o_done=%b o_ready=%b required 0/1",
               cur_done(), cur_ready());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_valid_a = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({o_ready_a, o_sym_valid_a, o_done_a, o_busy_a, o_sym_a, o_ready_b} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs rdy=%b vld=%b done=%b busy=%b sym=%b rdy_b=%b required all 0",
               o_ready_a, o_sym_valid_a, o_done_a, o_busy_a, o_sym_a, o_ready_b);
    end
    i_valid_a = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (o_ready_a !== 1'b1 || o_ready_b !== 1'b1 || o_busy_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ready_after_reset rdy_a=%b rdy_b=%b busy=%b required 1/1/0",
               o_ready_a, o_ready_b, o_busy_a);
    end
  endtask

  task automatic test_known_vectors();
    run_frame(8'h01, 1'b0, 1'b0);
    vectors++;
    if (got_len !== 10 || done_cycles !== 11) begin
      miscompares++;
      $display("[TB] FAIL h01_len symbols=%0d done_at=%0d required 10/11", got_len, done_cycles);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (got_syms[i] !== E01[i]) begin
        miscompares++;
        $display("[TB] FAIL h01_sym%0d got=%b required %b", i, got_syms[i], E01[i]);
      end
    end
    run_frame(8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (got_syms[i] !== EFF[i]) begin
        miscompares++;
        $display("[TB] FAIL hFF_sym%0d got=%b required %b", i, got_syms[i], EFF[i]);
      end
    end
  endtask

  task automatic test_random_stalls();
    logic [7:0] w;
    for (int n = 0; n < 8; n++) begin
      w = (n == 0) ? 8'hA5 : 8'($urandom);
      model_frame(w, 1'b1);
      run_frame(w, 1'b1, 1'b0);
      vectors++;
      if (got_len !== exp_len) begin
        miscompares++;
        $display("[TB] FAIL stall_len word=%h symbols=%0d required %0d", w, got_len, exp_len);
      end
      for (int i = 0; i < exp_len; i++) begin
        vectors++;
        if (got_syms[i] !== exp_syms[i]) begin
          miscompares++;
          $display("[TB] FAIL stall_sym word=%h idx=%0d got=%b required %b",
                   w, i, got_syms[i], exp_syms[i]);
        end
      end
    end
  endtask

  // i_valid stays high and i_data keeps changing while the DUT is busy.
  task automatic test_busy_ignore();
    logic [7:0] w1, w2;
    int n;
    w1 = 8'($urandom);
    model_frame(w1, 1'b1);
    sel_b = 1'b0;
    got_len = 0;
    for (int i = 0; i < 32; i++) got_syms[i] = 2'bxx;
    @(negedge clk);
    i_data = w1;
    i_valid_a = 1'b1;
    i_sym_ready = 1'b1;
    n = 0;
    while (!o_ready_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      i_data = 8'($urandom);
      if (o_sym_valid_a && got_len < 32) begin
        got_syms[got_len] = o_sym_a;
        got_len++;
      end
    end while (!o_ready_a && n < 60);
    w2 = i_data;
    vectors++;
    if (n !== 12) begin
      miscompares++;
      $display("[TB] FAIL accept_spacing cycles=%0d required 12", n);
    end
    for (int i = 0; i < exp_len; i++) begin
      vectors++;
      if (got_syms[i] !== exp_syms[i]) begin
        miscompares++;
        $display("[TB] FAIL busy_sym idx=%0d got=%b required %b", i, got_syms[i], exp_syms[i]);
      end
    end
    @(negedge clk);
    i_valid_a = 1'b0;
    model_frame(w2, 1'b1);
    got_len = 0;
    n = 0;
    while (!o_done_a && n < 60) begin
      if (o_sym_valid_a && got_len < 32) begin
        got_syms[got_len] = o_sym_a;
        got_len++;
      end
      @(negedge clk);
      n++;
    end
    vectors++;
    if (got_len !== exp_len) begin
      miscompares++;
      $display("[TB] FAIL second_word_len symbols=%0d required %0d", got_len, exp_len);
    end
    for (int i = 0; i < exp_len; i++) begin
      vectors++;
      if (got_syms[i] !== exp_syms[i]) begin
        miscompares++;
        $display("[TB] FAIL second_word_sym idx=%0d got=%b required %b", i, got_syms[i], exp_syms[i]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int  cnt;
    int  n;
    bit  bad;
    @(negedge clk);
    i_data = 8'h01;
    i_valid_a = 1'b1;
    i_sym_ready = 1'b1;
    n = 0;
    while (!o_ready_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    i_valid_a = 1'b0;
    cnt = 0;
    n = 0;
    while (cnt < 4 && n < 50) begin
      if (o_sym_valid_a) cnt++;
      @(negedge clk);
      n++;
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (o_sym_valid_a !== 1'b0 || o_done_a !== 1'b0 || o_busy_a !== 1'b0 || o_sym_a !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL mid_reset vld=%b done=%b busy=%b sym=%b required 0/0/0/00",
               o_sym_valid_a, o_done_a, o_busy_a, o_sym_a);
    end
    @(negedge clk);
    rst = 1'b1;
    bad = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (o_done_a !== 1'b0 || o_sym_valid_a !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL post_reset_quiet activity=1 required 0");
    end
    run_frame(8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (got_syms[i] !== E01[i]) begin
        miscompares++;
        $display("[TB] FAIL after_reset_sym%0d got=%b required %b", i, got_syms[i], E01[i]);
      end
    end
  endtask

  task automatic test_no_tail();
    logic [7:0] w;
    run_frame(8'h01, 1'b0, 1'b1);
    vectors++;
    if (got_len !== 8 || done_cycles !== 9) begin
      miscompares++;
      $display("[TB] FAIL notail_len symbols=%0d done_at=%0d required 8/9", got_len, done_cycles);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (got_syms[i] !== E01[i]) begin
        miscompares++;
        $display("[TB] FAIL notail_sym%0d got=%b required %b", i, got_syms[i], E01[i]);
      end
    end
    for (int n = 0; n < 4; n++) begin
      w = 8'($urandom);
      model_frame(w, 1'b0);
      run_frame(w, 1'b1, 1'b1);
      vectors++;
      if (got_len !== 8) begin
        miscompares++;
        $display("[TB] FAIL notail_rand_len word=%h symbols=%0d required 8", w, got_len);
      end
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (got_syms[i] !== exp_syms[i]) begin
          miscompares++;
          $display("[TB] FAIL notail_rand_sym word=%h idx=%0d got=%b required %b",
                   w, i, got_syms[i], exp_syms[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_random_stalls();
    test_busy_ignore();
    test_reset_mid_frame();
    test_no_tail();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_encoder_framer.md
CONV_ENCODER_FRAMER -- requirements
Module: conv_encoder_framer

Interface
REQ-001 Parameter DATA_W, default 8, sets the number of information bits per frame word.
REQ-002 Parameter G0, default 3'b111, is the generator polynomial for output symbol bit 1, as taps {current bit, state[1], state[0]}.
REQ-003 Parameter G1, default 3'b101, is the generator polynomial for output symbol bit 0, with the same tap order.
REQ-004 Parameter TAIL_EN, default 1, appends K-1=2 zero tail bits per frame when 1.
REQ-005 Port clk  input  1  is the clock; all state updates occur on its rising edge.
REQ-006 Port rst  input  1  is the reset: asynchronous, active-low.
REQ-007 Port i_data  input  DATA_W  is the information word to encode.
REQ-008 Port i_valid  input  1  indicates that i_data is valid.
REQ-009 Port o_ready  output  1  indicates the block can accept a word (high only in IDLE).
REQ-010 Port o_sym  output  2  is the encoded symbol {g0,g1}.
REQ-011 Port o_sym_valid  output  1  indicates that o_sym is valid.
REQ-012 Port i_sym_ready  input  1  is downstream acceptance of o_sym.
REQ-013 Port o_busy  output  1  is high in every state except IDLE.
REQ-014 Port o_done  output  1  is a one-cycle pulse after the last symbol of a frame is accepted.

Function
REQ-015 The FSM SHALL have the states IDLE, ENCODE, TAIL and DONE, encoded in 2 bits.
REQ-016 In IDLE, the accept condition is i_valid && o_ready: word register <= i_data, encoder state <= 2'b00, bit index <= 0, next state ENCODE.
REQ-017 In IDLE without i_valid, the block SHALL hold, with o_sym_valid = 0.
REQ-018 Bit order SHALL be LSB first: in ENCODE the current bit b = word[bit index].
REQ-019 In ENCODE and TAIL: g0 = ^(G0 & {b,state}), g1 = ^(G1 & {b,state}), o_sym = {g0,g1}, and o_sym_valid = 1.
REQ-020 In TAIL, b SHALL be 0.
REQ-021 A symbol transfers on o_sym_valid && i_sym_ready; on a transfer, state <= {b, state[1]} and the bit or tail counter increments.
REQ-022 While i_sym_ready = 0, o_sym and all internal state SHALL hold stable, with no symbol dropped or duplicated.
REQ-023 A transfer of bit index DATA_W-1 SHALL move the FSM to TAIL if TAIL_EN = 1, or to DONE otherwise.
REQ-024 TAIL SHALL emit exactly 2 symbols; the transfer of the 2nd symbol moves the FSM to DONE.
REQ-025 DONE SHALL last exactly one cycle with o_done = 1, o_sym_valid = 0 and o_ready = 0, then move to IDLE.
REQ-026 The first symbol SHALL be valid on the cycle after acceptance (latency 1 cycle).
REQ-027 Throughput SHALL be 1 symbol per cycle with i_sym_ready held high.
REQ-028 A frame SHALL take DATA_W + 2*TAIL_EN + 2 cycles, from accept to the first possible next accept.
REQ-029 i_valid asserted while o_busy = 1 SHALL be ignored; i_data is not sampled and no internal state is affected.
REQ-030 The encoder state SHALL start each frame at 2'b00, matching the decoder start state s0.
REQ-031 With TAIL_EN = 1, the encoder state SHALL end each frame at 2'b00.
REQ-032 The bit index SHALL be ceil(log2(DATA_W))+1 bits wide and SHALL never exceed DATA_W-1 in ENCODE.

Reset
REQ-033 On rst = 0, outputs SHALL take: o_sym = 0, o_sym_valid = 0, o_done = 0, o_busy = 0, o_ready = 0 while rst is low.
REQ-034 On rst = 0, internal state SHALL take: FSM = IDLE, encoder state = 0, counters = 0, word register = 0.
REQ-035 After rst deasserts, o_ready SHALL be 1 from the first clock edge.
REQ-036 Reset mid-frame SHALL abort the frame immediately, with no o_done and no further symbols.

Verification
REQ-037 Defaults, i_data = 8'h01, i_sym_ready = 1 -> symbols 11,10,11,00,00,00,00,00, then tail 00,00, then o_done pulse.
REQ-038 i_data = 8'hFF -> symbols 11,01,10,10,10,10,10,10, then tail 01,11; final encoder state 00.
REQ-039 i_data = 8'hA5 with i_sym_ready toggling pseudo-randomly -> symbol sequence identical to the i_sym_ready = 1 run, and o_sym stable during every stall.
REQ-040 i_valid held high through a frame with i_data changing mid-frame -> only the word present at the accept cycle is encoded; next accept occurs exactly 12 cycles after the first.
REQ-041 rst pulsed low after the 4th symbol -> o_sym_valid = 0 and o_done = 0 immediately; next frame 8'h01 reproduces the REQ-037 sequence.
REQ-042 TAIL_EN = 0, i_data = 8'h01 -> 8 symbols with no tail, o_done on the cycle after the 8th transfer, 10 cycles frame-to-frame.
